// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between the CPU control sequencer and a data-break
//   (DMA) channel. Data break has priority, but once MAX_BREAK consecutive
//   data-break grants have gone by while the CPU was waiting, the CPU gets
//   the next grant. Address, write data and operation are latched at grant.
//   The memory completion pulse (or a timeout abort) is routed back to the
//   owner as a one-cycle valid.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   cpu_read/cpu_write      CPU request, held until cpu_valid
//   cpu_addr/cpu_wdata      CPU address / write data
//   cpu_valid               one-cycle CPU completion pulse
//   db_read/db_write        data-break request, held until db_valid
//   db_addr/db_wdata        data-break address / write data
//   db_valid                one-cycle data-break completion pulse
//   rdata                   read data, qualified by cpu_valid/db_valid
//   timeout_err             high with the valid pulse of an aborted access
//   mem_read/mem_write      memory strobes
//   mem_addr/mem_wdata      latched address / write data
//   mem_rdata/mem_ready     memory read data and one-cycle completion
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 12,
  parameter int MAX_BREAK = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_valid,
  input  logic          db_read,
  input  logic          db_write,
  input  logic [AW-1:0] db_addr,
  input  logic [DW-1:0] db_wdata,
  output logic          db_valid,
  output logic [DW-1:0] rdata,
  output logic          timeout_err,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int BW = $clog2(MAX_BREAK + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BRK_MAX  = BW'(MAX_BREAK);
  localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DB_ACC, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_brk_cnt, w_brk_nxt;
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic          r_op_write;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic w_cpu_req, w_db_req;
  logic w_grant_cpu, w_grant_db;
  logic w_finish, w_timeout, w_access;

  assign w_cpu_req = cpu_read | cpu_write;
  assign w_db_req  = db_read  | db_write;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_brk_nxt   = r_brk_cnt;
    w_tmr_nxt   = r_tmr;
    w_grant_cpu = 1'b0;
    w_grant_db  = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_tmr_nxt = '0;
        // Data break wins unless it has already had its run of grants
        // while the CPU sat waiting.
        if (w_db_req && (r_brk_cnt < BRK_MAX || !w_cpu_req)) begin
          w_grant_db  = 1'b1;
          w_state_nxt = DB_ACC;
          w_brk_nxt   = w_cpu_req ? r_brk_cnt + BW'(1) : '0;
        end else if (w_cpu_req) begin
          w_grant_cpu = 1'b1;
          w_state_nxt = CPU_ACC;
          w_brk_nxt   = '0;
        end else begin
          w_brk_nxt   = '0;
        end
      end
      CPU_ACC, DB_ACC: begin
        w_tmr_nxt = r_tmr + TW'(1);
        if (mem_ready) begin
          w_finish = 1'b1;
        end else if (TIMEOUT != 0 && r_tmr == TMR_LAST) begin
          w_finish  = 1'b1;
          w_timeout = 1'b1;
        end
        if (w_finish) w_state_nxt = DONE;
      end
      DONE: begin
        w_tmr_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes decode the registered state, so a reset mid-access drops them
  // on the following cycle; the completion outputs are masked by reset so an
  // access cut short never reports.
  assign w_access    = (r_state == CPU_ACC) || (r_state == DB_ACC);
  assign mem_read    = w_access & ~r_op_write;
  assign mem_write   = w_access &  r_op_write;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign cpu_valid   = w_finish & (r_state == CPU_ACC) & ~reset;
  assign db_valid    = w_finish & (r_state == DB_ACC)  & ~reset;
  assign timeout_err = w_timeout & ~reset;
  assign rdata       = (w_finish & mem_ready & ~r_op_write & ~reset) ? mem_rdata : '0;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the latched address/data are reset too, since mem_addr and
    // mem_wdata are visible outputs that must read 0 out of reset.
    if (reset) begin
      r_state    <= IDLE;
      r_brk_cnt  <= '0;
      r_tmr      <= '0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_brk_cnt <= w_brk_nxt;
      r_tmr     <= w_tmr_nxt;
      if (w_grant_cpu) begin
        r_op_write <= cpu_write;
        r_addr     <= cpu_addr;
        r_wdata    <= cpu_wdata;
      end else if (w_grant_db) begin
        r_op_write <= db_write;
        r_addr     <= db_addr;
        r_wdata    <= db_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scenarios followed by randomized traffic, each cycle compared
//   against a transaction-style reference model of the arbiter.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 12, DW = 12, MAX_BREAK = 4, TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_read, cpu_write, db_read, db_write;
  logic [AW-1:0] cpu_addr, db_addr;
  logic [DW-1:0] cpu_wdata, db_wdata;
  logic          cpu_valid, db_valid, timeout_err, mem_read, mem_write;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BREAK(MAX_BREAK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_valid(cpu_valid),
    .db_read(db_read), .db_write(db_write), .db_addr(db_addr),
    .db_wdata(db_wdata), .db_valid(db_valid),
    .rdata(rdata), .timeout_err(timeout_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how long the access has run, whether
  // the post-access dead cycle is pending, and the data-break streak length.
  int            m_owner;   // 0 none, 1 cpu, 2 data break
  int            m_age;
  bit            m_cool;
  int            m_streak;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  // Outputs sampled by the last step()
  logic          s_cv, s_dv, s_to, s_mr, s_mw;
  logic [DW-1:0] s_rdata, s_mwd;
  logic [AW-1:0] s_ma;

  task automatic model_reset();
    m_owner = 0; m_age = 0; m_cool = 0; m_streak = 0;
    m_wr = 0; m_addr = '0; m_wdata = '0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, return just after it so the caller can drive the next inputs.
  task automatic step();
    bit            fin;
    logic [DW-1:0] e_rdata;
    bit            creq, dreq;
    @(negedge clk);
    fin = (m_owner != 0) && !reset &&
          (mem_ready || (TIMEOUT != 0 && m_age == TIMEOUT - 1));
    e_rdata = (fin && mem_ready && !m_wr) ? mem_rdata : '0;
    s_cv = cpu_valid; s_dv = db_valid; s_to = timeout_err; s_rdata = rdata;
    s_mr = mem_read; s_mw = mem_write; s_ma = mem_addr; s_mwd = mem_wdata;
    check("cpu_valid",   s_cv,   fin && m_owner == 1);
    check("db_valid",    s_dv,   fin && m_owner == 2);
    check("timeout_err", s_to,   fin && !mem_ready);
    check("rdata",       s_rdata, e_rdata);
    check("mem_read",    s_mr,   m_owner != 0 && !m_wr);
    check("mem_write",   s_mw,   m_owner != 0 &&  m_wr);
    check("mem_addr",    s_ma,   m_addr);
    check("mem_wdata",   s_mwd,  m_wdata);
    check("one_valid",   s_cv & s_dv, 1'b0);
    @(posedge clk);
    creq = cpu_read | cpu_write;
    dreq = db_read  | db_write;
    if (reset) model_reset();
    else if (m_owner != 0) begin
      if (fin) begin m_owner = 0; m_cool = 1; end
      else m_age++;
    end else if (m_cool) m_cool = 0;
    else if (dreq && (m_streak < MAX_BREAK || !creq)) begin
      m_owner = 2; m_age = 0; m_wr = db_write; m_addr = db_addr; m_wdata = db_wdata;
      m_streak = creq ? m_streak + 1 : 0;
    end else if (creq) begin
      m_owner = 1; m_age = 0; m_wr = cpu_write; m_addr = cpu_addr; m_wdata = cpu_wdata;
      m_streak = 0;
    end else m_streak = 0;
    #1;
  endtask

  initial begin
    int nd, nv, k;
    bit cpu_seen;
    model_reset();
    reset = 1; cpu_read = 0; cpu_write = 0; db_read = 0; db_write = 0;
    cpu_addr = '0; cpu_wdata = '0; db_addr = '0; db_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    @(posedge clk); #1;
    step(); step();
    reset = 0;
    step();
    check("rst_mem_addr", s_ma, '0);
    check("rst_strobes", {s_mr, s_mw}, 2'b00);

    // Lone CPU read, memory answers two cycles after the strobe rises
    cpu_read = 1; cpu_addr = 12'o200;
    step();                                   // arbitration cycle
    step(); check("lone_strobe", s_mr, 1'b1);
    step();
    mem_ready = 1; mem_rdata = 12'o7402;
    step();
    check("lone_valid", s_cv, 1'b1);
    check("lone_rdata", s_rdata, 12'o7402);
    check("lone_addr",  s_ma, 12'o200);
    cpu_read = 0; mem_ready = 0;
    step(); check("lone_single_pulse", s_cv, 1'b0);
    step();

    // Simultaneous CPU write and data-break read: data break goes first
    cpu_write = 1; cpu_addr = 12'o100; cpu_wdata = 12'o1234;
    db_read = 1; db_addr = 12'o300;
    step();
    mem_ready = 1; mem_rdata = 12'o0055;
    step();
    check("sim_db_first", s_dv, 1'b1);
    check("sim_db_addr",  s_ma, 12'o300);
    db_read = 0; mem_ready = 0;
    step(); step();
    mem_ready = 1;
    step();
    check("sim_cpu_valid", s_cv, 1'b1);
    check("sim_cpu_addr",  s_ma, 12'o100);
    check("sim_cpu_wdata", s_mwd, 12'o1234);
    check("sim_cpu_write", s_mw, 1'b1);
    cpu_write = 0; mem_ready = 0;
    step(); step();

    // Data break held continuously with the CPU waiting
    db_read = 1; db_addr = 12'o400; cpu_read = 1; cpu_addr = 12'o401; mem_ready = 1;
    nd = 0; cpu_seen = 0;
    for (int i = 0; i < 60 && !cpu_seen; i++) begin
      step();
      if (s_dv) nd++;
      if (s_cv) cpu_seen = 1;
    end
    check("fair_cpu_served", cpu_seen, 1'b1);
    check("fair_db_grants", nd, MAX_BREAK);
    cpu_read = 0;
    step();
    db_read = 0;
    for (int i = 0; i < 6; i++) step();
    mem_ready = 0;

    // No memory response: abort on the 15th access cycle
    cpu_read = 1; cpu_addr = 12'o123;
    step();
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      step();
      if (s_cv) k = i;
    end
    check("tmo_cycle", k, TIMEOUT);
    check("tmo_err",   s_to, 1'b1);
    check("tmo_rdata", s_rdata, '0);
    cpu_read = 0;
    step(); check("tmo_strobe_drop", s_mr, 1'b0);
    step();

    // Reset in the middle of a data-break access
    db_write = 1; db_addr = 12'o777; db_wdata = 12'o4321;
    step();
    step(); check("rst_acc_strobe", s_mw, 1'b1);
    reset = 1; mem_ready = 1;
    step(); check("rst_no_valid", s_dv, 1'b0);
    reset = 0; mem_ready = 0; db_write = 0;
    step(); check("rst_strobe_drop", {s_mr, s_mw}, 2'b00);
    step();

    // ISZ: read then write to the same word, back to back
    cpu_read = 1; cpu_addr = 12'o050; mem_ready = 1; mem_rdata = 12'o0007;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_cv) begin
        nv++;
        if (nv == 1) begin
          check("isz_read_op", s_mr, 1'b1);
          cpu_read = 0; cpu_write = 1; cpu_wdata = 12'o0010;
        end else begin
          check("isz_write_op", s_mw, 1'b1);
          check("isz_write_data", s_mwd, 12'o0010);
          cpu_write = 0;
        end
      end
    end
    check("isz_valid_count", nv, 2);
    mem_ready = 0;
    step();

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (s_cv || !(cpu_read | cpu_write)) begin
        if ($urandom_range(0, 1) == 0) begin
          cpu_read = $urandom_range(0, 1) == 1;
          cpu_write = $urandom_range(0, 2) == 0;
          cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
        end else begin
          cpu_read = 0; cpu_write = 0;
        end
      end
      if (s_dv || !(db_read | db_write)) begin
        if ($urandom_range(0, 1) == 0) begin
          db_read = $urandom_range(0, 1) == 1;
          db_write = $urandom_range(0, 2) == 0;
          db_addr = AW'($urandom); db_wdata = DW'($urandom);
        end else begin
          db_read = 0; db_write = 0;
        end
      end
      if ((cyc % 500) < 45) mem_ready = 0;
      else mem_ready = $urandom_range(0, 2) == 0;
      mem_rdata = DW'($urandom);
      reset = $urandom_range(0, 299) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
